timeslice_arbiter: RTL

- Round-robin time-slice arbiter that shares one resource among NREQ requesters.
- Slice length is measured in ticks from an external mod-M prescaler: its max_tick drives tick_in.
- Each grant lasts at most SLICE ticks. The owner can release early with done, or by dropping req.
- Sits between the requester blocks and the shared datapath. Grant vectors drive the datapath's select and enable.

---
 rtl/timeslice_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/timeslice_arbiter.sv
// Round-robin time-slice arbiter: one owner at a time, each grant bounded by
// SLICE prescaler ticks, with early release via done or a dropped req.
module timeslice_arbiter #(
  parameter int NREQ  = 4,
  parameter int SLICE = 8,
  localparam int IW   = $clog2(NREQ),
  localparam int SW   = $clog2(SLICE + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick_in,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_id,
  output logic            busy,
  output logic            slice_expired,
  output logic [SW-1:0]   slice_cnt
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick;
  logic [IW-1:0] next_ptr;
  logic          early;
  logic          expire;

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    early    = done[grant_id] | ~req[grant_id];
    expire   = tick_in && (slice_cnt == SW'(SLICE - 1));
    next_ptr = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= '0;
      grant_id      <= '0;
      busy          <= 1'b0;
      slice_expired <= 1'b0;
      slice_cnt     <= '0;
      rr_ptr        <= '0;
    end else begin
      slice_expired <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= GRANT;
            grant     <= NREQ'(1) << pick;
            grant_id  <= pick;
            busy      <= 1'b1;
            slice_cnt <= '0;
          end
        end
        GRANT: begin
          // Early release takes priority: expiry is only flagged when the
          // owner was still holding the resource.
          if (early || expire) begin
            state         <= IDLE;
            grant         <= '0;
            grant_id      <= '0;
            busy          <= 1'b0;
            slice_cnt     <= '0;
            rr_ptr        <= next_ptr;
            slice_expired <= expire & ~early;
          end else if (tick_in) begin
            slice_cnt <= slice_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
